ethernet_encapsulation: RTL
===========================

// Module: ethernet_encapsulation
// PURPOSE
//  GMII transmit-side framer, the counterpart of ethernet_decapsulation.
//  Pulls payload bytes from the TX buffer and emits one complete Ethernet II frame on GMII:
//  preamble, SFD, dst/src MAC, length, payload, zero pad, CRC32 FCS, then the inter-frame gap.
//  Sits between the TX payload FIFO and the GMII PHY interface.
// PARAMETERS
//  destination_mac_addr  48'h023528fbdd66  DA field; byte [47:40] is sent first
//  source_mac_addr       48'h072227acdb65  SA field; byte [47:40] is sent first
//  IFG_BYTES             12                idle cycles after each frame (tx_en=0)
//  MIN_PAYLOAD           46                pad threshold; payload is zero-padded to this length
// PORTS
//  clk           in   1   GMII TX clock, 125 MHz; the only clock
//  rst           in   1   asynchronous, active-low reset
//  tx_start      in   1   request a frame; sampled only when busy=0
//  payload_len   in   11  payload bytes, 1..1500; latched with tx_start
//  busy          out  1   high from the cycle after tx_start is accepted to the end of the IFG
//  pl_data       in   8   payload byte
//  pl_valid      in   1   pl_data is valid
//  pl_ready      out  1   framer consumes pl_data this cycle
//  gmii_tx_d     out  8   GMII data
//  gmii_tx_en    out  1   GMII transmit enable
//  gmii_tx_er    out  1   GMII transmit error
//  frame_done    out  1   1-cycle pulse on the last FCS byte of a good frame
//  underrun      out  1   1-cycle pulse when a payload byte was missing
//  len_err       out  1   1-cycle pulse when tx_start is rejected for a bad length
// BEHAVIOUR
//  Reset (async assert)
//   - All outputs go to 0 immediately.
//   - The FSM goes to IDLE; the CRC register is set to 32'hFFFFFFFF.
//   - Reset mid-frame truncates the frame with no FCS; tx_en falls at once.
//  Outputs
//   - gmii_tx_d, gmii_tx_en and gmii_tx_er are registered.
//   - pl_ready is combinational from state.
//  FSM states: IDLE, PRE, SFD, DST, SRC, LEN, PAY, PAD, FCS, IFG.
//   - Each non-IDLE state drives one byte per clock; a down-counter tracks the byte index.
//  IDLE
//   - tx_start=1 with payload_len in 1..1500: latch the length, go to PRE.
//   - First 0x55 appears on the next edge with tx_en=1.
//   - A length of 0 or >1500 gives a len_err pulse and the FSM stays in IDLE.
//  Byte sequence per state
//   - PRE: 7 x 0x55.  SFD: 0xD5.  DST: 6 bytes.  SRC: 6 bytes.
//   - LEN: payload_len zero-extended to 16 bits, MSB byte first.
//   - PAY: payload_len bytes from the handshake.
//   - PAD: max(0, MIN_PAYLOAD - payload_len) bytes of 0x00.
//   - FCS: 4 bytes, then IFG for IFG_BYTES cycles, then back to IDLE.
//  Payload handshake
//   - pl_ready is high for exactly payload_len consecutive cycles.
//   - It starts in the cycle the 2nd LEN byte is driven.
//   - A byte is accepted when pl_valid & pl_ready, and is on gmii_tx_d after that edge.
//  Underrun
//   - Condition: pl_ready=1 & pl_valid=0.
//   - That byte is driven with tx_en=1, tx_er=1, d=0x00, and underrun pulses.
//   - FSM jumps to IFG; no FCS, no frame_done.
//  CRC
//   - Covers DST through PAD.
//   - Reflected polynomial 0xEDB88320, init 32'hFFFFFFFF, processed LSB-first.
//   - FCS = ~crc, sent low byte first, i.e. identical to what the decapsulation checker verifies.
//   - CRC is re-initialised in PRE.
//  Frame length and start timing
//   - Bytes with tx_en=1 = 8 + 14 + max(len, 46) + 4.
//   - tx_start while busy=1 is ignored; no queuing.
//   - Earliest next frame: tx_start in the first IDLE cycle after IFG.
//   - busy=0 in that cycle, so the gap on the wire is >= IFG_BYTES+1 cycles.
// TESTING
//  1. len=46, bytes 0x00..0x2D -> 72 tx_en cycles; 55x7,D5, DA, SA, 00 2E, payload;
//     FCS equals the software CRC32; frame_done on cycle 72.
//  2. len=1, byte 0xAB -> LEN=00 01, 1 payload byte + 45 x 0x00 pad; 72 tx_en cycles; pl_ready high 1 cycle.
//  3. len=1500 -> 1526 tx_en cycles; pl_ready high 1500 cycles; no pad.
//  4. pl_valid dropped on payload byte 10 of 60 -> that byte has tx_er=1; underrun pulse; tx_en low next
//     cycle; no frame_done.
//  5. tx_start with len=0 and len=1501 -> len_err pulse, tx_en stays 0, busy stays 0.
//  6. tx_start held high continuously -> frames back-to-back with >=13 idle cycles between;
//     rst low mid-DST -> all outputs 0 same cycle; next tx_start frames cleanly.

Source files
------------

// File: rtl/ethernet_encapsulation.sv
// GMII transmit framer: preamble, SFD, DA, SA, length, payload, zero pad, CRC32 FCS, then IFG.
// The state/counter registers always describe the byte currently on gmii_tx_d.
module ethernet_encapsulation #(
  parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
  parameter logic [47:0] source_mac_addr      = 48'h072227acdb65,
  parameter int          IFG_BYTES            = 12,
  parameter int          MIN_PAYLOAD          = 46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [10:0] payload_len,
  output logic        busy,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  gmii_tx_d,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        frame_done,
  output logic        underrun,
  output logic        len_err,
  output logic [3:0]  dbg_state
);

  // Payload handshake: a byte transfers on a rising edge where pl_valid & pl_ready;
  // pl_ready depends only on the current state, never on pl_valid.

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PAY, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  tx_d_q, tx_d_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;
  logic        len_err_q, len_err_d;

  logic [10:0] cm1;
  logic [31:0] fcs;
  logic        crc_en;
  logic        len_ok;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Index 5 selects the first byte on the wire ([47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = m[7:0];
      3'd1:    r = m[15:8];
      3'd2:    r = m[23:16];
      3'd3:    r = m[31:24];
      3'd4:    r = m[39:32];
      default: r = m[47:40];
    endcase
    return r;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] f, input logic [1:0] idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = f[7:0];
      2'd1:    r = f[15:8];
      2'd2:    r = f[23:16];
      default: r = f[31:24];
    endcase
    return r;
  endfunction

  assign pl_ready = ((state_q == S_LEN) && (cnt_q == 11'd0)) ||
                    ((state_q == S_PAY) && (cnt_q != 11'd0));
  assign busy     = (state_q != S_IDLE);
  assign cm1      = cnt_q - 11'd1;
  assign fcs      = ~crc_q;
  assign len_ok   = (payload_len != 11'd0) && (payload_len <= 11'd1500);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    crc_d        = crc_q;
    tx_d_d       = 8'h00;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    len_err_d    = 1'b0;
    crc_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (len_ok) begin
            state_d = S_PRE;
            cnt_d   = 11'd6;
            len_d   = payload_len;
            tx_d_d  = 8'h55;
            tx_en_d = 1'b1;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        tx_en_d = 1'b1;
        crc_d   = 32'hFFFFFFFF;
        if (cnt_q != 11'd0) begin
          cnt_d  = cm1;
          tx_d_d = 8'h55;
        end else begin
          state_d = S_SFD;
          tx_d_d  = 8'hD5;
        end
      end
      S_SFD: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        state_d = S_DST;
        cnt_d   = 11'd5;
        tx_d_d  = destination_mac_addr[47:40];
      end
      S_DST: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        if (cnt_q != 11'd0) begin
          cnt_d  = cm1;
          tx_d_d = mac_byte(destination_mac_addr, cm1[2:0]);
        end else begin
          state_d = S_SRC;
          cnt_d   = 11'd5;
          tx_d_d  = source_mac_addr[47:40];
        end
      end
      S_SRC: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        if (cnt_q != 11'd0) begin
          cnt_d  = cm1;
          tx_d_d = mac_byte(source_mac_addr, cm1[2:0]);
        end else begin
          state_d = S_LEN;
          cnt_d   = 11'd1;
          tx_d_d  = {5'd0, len_q[10:8]};
        end
      end
      S_LEN: begin
        tx_en_d = 1'b1;
        if (cnt_q != 11'd0) begin
          crc_en = 1'b1;
          cnt_d  = 11'd0;
          tx_d_d = len_q[7:0];
        end
      end
      S_PAY: begin
        tx_en_d = 1'b1;
        if (cnt_q == 11'd0) begin
          if (len_q < 11'(MIN_PAYLOAD)) begin
            crc_en  = 1'b1;
            state_d = S_PAD;
            cnt_d   = 11'(MIN_PAYLOAD) - len_q - 11'd1;
            tx_d_d  = 8'h00;
          end else begin
            state_d = S_FCS;
            cnt_d   = 11'd3;
            tx_d_d  = fcs[7:0];
          end
        end
      end
      S_PAD: begin
        tx_en_d = 1'b1;
        if (cnt_q != 11'd0) begin
          crc_en = 1'b1;
          cnt_d  = cm1;
          tx_d_d = 8'h00;
        end else begin
          state_d = S_FCS;
          cnt_d   = 11'd3;
          tx_d_d  = fcs[7:0];
        end
      end
      S_FCS: begin
        if (cnt_q != 11'd0) begin
          tx_en_d      = 1'b1;
          cnt_d        = cm1;
          tx_d_d       = fcs_byte(fcs, 2'd3 - cm1[1:0]);
          frame_done_d = (cm1 == 11'd0);
        end else begin
          state_d = S_IFG;
          cnt_d   = 11'(IFG_BYTES - 1);
        end
      end
      S_IFG: begin
        if (cnt_q != 11'd0) begin
          cnt_d = cm1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Offered payload slot: take the byte, or poison it and abandon the frame.
    if (pl_ready) begin
      tx_en_d = 1'b1;
      if (pl_valid) begin
        crc_en  = 1'b1;
        state_d = S_PAY;
        cnt_d   = (state_q == S_LEN) ? (len_q - 11'd1) : cm1;
        tx_d_d  = pl_data;
      end else begin
        state_d    = S_IFG;
        cnt_d      = 11'(IFG_BYTES);
        tx_d_d     = 8'h00;
        tx_er_d    = 1'b1;
        underrun_d = 1'b1;
      end
    end

    if (crc_en) begin
      crc_d = crc32_byte(crc_q, tx_d_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 11'd0;
      len_q        <= 11'd0;
      crc_q        <= 32'hFFFFFFFF;
      tx_d_q       <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      crc_q        <= crc_d;
      tx_d_q       <= tx_d_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      len_err_q    <= len_err_d;
    end
  end

  assign gmii_tx_d  = tx_d_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign len_err    = len_err_q;
  assign dbg_state  = state_q;

endmodule
